// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with threshold flags, occupancy count,
// optional first-word-fall-through read, synchronous flush and sticky error flags.
module fifo_sync_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int DEPTH = 1 << ASIZE;
  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr, rptr;
  logic we, re;
  assign wfull         = count == (ASIZE+1)'(DEPTH);
  assign rempty        = count == '0;
  assign walmost_full  = count >= (ASIZE+1)'(AFULL_TH);
  assign ralmost_empty = count <= (ASIZE+1)'(AEMPTY_TH);
  assign we = winc && !wfull && !clr;
  assign re = rinc && !rempty && !clr;
  // Gating on rst keeps a write from landing while reset is held.
  always_ff @(posedge clk)
    if (rst && we) mem[wptr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + ASIZE'(we);
      rptr      <= rptr + ASIZE'(re);
      count     <= count + (ASIZE+1)'(we) - (ASIZE+1)'(re);
      overflow  <= overflow | (winc && wfull);
      underflow <= underflow | (rinc && rempty);
    end
  if (FWFT) begin : g_fwft
    assign rdata = mem[rptr];
  end else begin : g_std
    logic [DSIZE-1:0] rd_q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) rd_q <= '0;
      else if (clr) rd_q <= '0;
      else if (re) rd_q <= mem[rptr];
    assign rdata = rd_q;
  end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed checks of a standard-read and an FWFT instance
// driven by the same stimulus.
module tb_fifo_sync_flags;
  logic clk = 0, rst = 0, clr = 0, winc = 0, rinc = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata0, rdata1;
  logic wfull0, rempty0, wafull0, raempty0, ovf0, unf0;
  logic wfull1, rempty1, wafull1, raempty1, ovf1, unf1;
  logic [4:0] count0, count1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(wafull0),
    .ralmost_empty(raempty0), .count(count0), .overflow(ovf0), .underflow(unf0));

  fifo_sync_flags #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(wafull1),
    .ralmost_empty(raempty1), .count(count1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] val(input int n);
    return 8'(n * 3 + 7);
  endfunction

  initial begin
    #3;
    chk("rst_count", count0, 0);
    chk("rst_rempty", rempty0, 1);
    chk("rst_raempty", raempty0, 1);
    chk("rst_wfull", wfull0, 0);
    chk("rst_wafull", wafull0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_count_fwft", count1, 0);
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 16; i++) begin
      wdata = 8'(i);
      winc = 1;
      step();
      chk("fill_count", count0, i);
      chk("fill_wfull", wfull0, i == 16);
      chk("fill_wafull", wafull0, i >= 12);
      chk("fill_raempty", raempty0, i <= 2);
      chk("fill_rempty", rempty0, 0);
      chk("fill_fwft_head", rdata1, 8'h01);
    end
    wdata = 8'hAA;
    step();
    chk("ovf_count", count0, 16);
    chk("ovf_set", ovf0, 1);
    chk("ovf_rdata_std", rdata0, 0);
    winc = 0;
    step();
    chk("ovf_sticky", ovf0, 1);
    chk("ovf_fwft", ovf1, 1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_fwft", rdata1, 8'(i));
      rinc = 1;
      step();
      chk("drain_std", rdata0, 8'(i));
      chk("drain_count", count0, 16 - i);
    end
    chk("drain_rempty", rempty0, 1);
    chk("drain_ovf_hold", ovf0, 1);
    chk("drain_unf", unf0, 0);
    step();
    chk("unf_set", unf0, 1);
    chk("unf_count", count0, 0);
    chk("unf_rdata", rdata0, 8'h10);
    rinc = 0;
    clr = 1;
    step();
    clr = 0;
    chk("clr_ovf", ovf0, 0);
    chk("clr_unf", unf0, 0);
    chk("clr_rdata", rdata0, 0);
    chk("clr_count", count0, 0);
    for (int n = 0; n < 10; n++) begin
      wdata = val(n);
      winc = 1;
      step();
    end
    chk("wrap_pre_count", count0, 10);
    rinc = 1;
    for (int j = 0; j < 40; j++) begin
      wdata = val(10 + j);
      chk("wrap_fwft", rdata1, val(j));
      step();
      chk("wrap_std", rdata0, val(j));
      chk("wrap_count", count0, 10);
    end
    winc = 0;
    rinc = 0;
    chk("wrap_ovf", ovf0, 0);
    chk("wrap_unf", unf0, 0);
    clr = 1;
    winc = 1;
    wdata = 8'hEE;
    step();
    clr = 0;
    chk("clr_prio_count", count0, 0);
    wdata = 8'h5C;
    step();
    winc = 0;
    chk("fwft_rempty", rempty1, 0);
    chk("fwft_rdata", rdata1, 8'h5C);
    chk("fwft_count", count1, 1);
    step();
    chk("fwft_hold", rdata1, 8'h5C);
    rinc = 1;
    step();
    rinc = 0;
    chk("fwft_read_rempty", rempty1, 1);
    chk("fwft_read_count", count1, 0);
    chk("std_read_data", rdata0, 8'h5C);
    winc = 1;
    for (int n = 0; n < 7; n++) begin
      wdata = 8'(n + 1);
      step();
    end
    chk("pre_rst_count", count0, 7);
    wdata = 8'h99;
    #2;
    rst = 0;
    #1;
    chk("arst_count", count0, 0);
    chk("arst_rempty", rempty0, 1);
    chk("arst_raempty", raempty0, 1);
    chk("arst_wafull", wafull0, 0);
    chk("arst_rdata", rdata0, 0);
    chk("arst_count_fwft", count1, 0);
    step();
    chk("arst_hold_count", count0, 0);
    winc = 0;
    @(negedge clk);
    rst = 1;
    rinc = 1;
    step();
    rinc = 0;
    chk("post_rst_unf", unf0, 1);
    chk("post_rst_count", count0, 0);
    chk("post_rst_rdata", rdata0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Single-clock synchronous FIFO with parametrised width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, selectable standard or first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags. It buffers data between producer and consumer logic inside one clock domain, where the two-clock FIFO's synchronisers add latency for no benefit.

## Interface
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; depth DEPTH = 2^ASIZE
- AFULL_TH, 12, walmost_full asserts when count >= AFULL_TH; legal range 1..DEPTH
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard read (registered rdata), 1 = first-word-fall-through

- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous assert, active-low
- clr  input  1  synchronous flush
- wdata  input  DSIZE  write data
- winc  input  1  write request
- rinc  input  1  read request
- rdata  output  DSIZE  read data
- wfull  output  1  count == DEPTH
- rempty  output  1  count == 0
- walmost_full  output  1  count >= AFULL_TH
- ralmost_empty  output  1  count <= AEMPTY_TH
- count  output  ASIZE+1  occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DSIZE register array. Write and read pointers are ASIZE bits and wrap modulo DEPTH. count register is ASIZE+1 bits.
- Write is accepted when winc && !wfull: mem[wptr] <= wdata, wptr <= wptr+1.
- Read is accepted when rinc && !rempty: rptr <= rptr+1.
- count next = count + accepted write - accepted read. Simultaneous accepted write and read leaves count unchanged.
- When full, a write is rejected even if a read is accepted in the same cycle.
- When empty, a read is rejected even if a write is accepted in the same cycle.
- A rejected write/read changes no pointer, count or memory state.
- winc && wfull sets overflow. rinc && rempty sets underflow. Both hold until rst or clr.
- All flags are decoded combinationally from the count register, so they change only at clock edges.
- FWFT=0:
  - rdata is a register loaded with mem[rptr] on an accepted read.
  - Otherwise rdata holds its previous value.
- FWFT=1:
  - rdata = mem[rptr] continuously; it is valid whenever !rempty.
  - An accepted read advances rdata to the next word after the edge.
  - rdata is undefined/don't-care while rempty.
- clr has priority over winc/rinc in the same cycle. At the next edge:
  - pointers and count go to 0.
  - overflow and underflow go to 0.
  - in FWFT=0, rdata goes to 0.
  - memory contents are not cleared.
- Pointer wrap from DEPTH-1 to 0 is seamless; data order is preserved across the wrap.

## Timing
- Reset values (rst low, asynchronous):
  - wptr = rptr = 0, count = 0
  - rempty = 1, ralmost_empty = 1
  - wfull = 0, walmost_full = 0
  - overflow = underflow = 0
  - rdata = 0
- Release of rst is synchronous to clk; the first write is accepted on the first rising edge with rst high.
- Write to flags: a write accepted at edge N updates count, rempty and the other flags after edge N.
- Write to data in FWFT=1: a word written into an empty FIFO at edge N is visible on rdata after edge N, with rempty = 0 in the same cycle.
- Read latency in FWFT=0: an accepted read at edge N presents the word on rdata after edge N (one cycle from the rinc cycle).
- Sustained throughput is one write and one read per cycle.
- A mid-operation rst aborts everything immediately; no partial write is committed after rst falls.

## Test plan
- Reset, then write 0x01..0x10 (16 words) at DSIZE=8, ASIZE=4 -> count reaches 16, wfull=1 after 16th edge; walmost_full=1 once count=12; ralmost_empty=0 once count=3.
- Full FIFO, winc=1 for one more cycle with wdata=0xAA -> write rejected, count stays 16, overflow=1 and remains 1; subsequent 16 reads return 0x01..0x10 in order, never 0xAA.
- Empty FIFO, rinc=1 -> underflow=1, count stays 0, rdata unchanged (FWFT=0); after clr pulse overflow=underflow=0.
- Fill 10 words, then drive winc=rinc=1 for 40 cycles with incrementing data -> count stays 10, pointers wrap at least twice, read stream exactly equals write stream delayed by 10 words.
- FWFT=1: write 0x5C into empty FIFO -> after that edge rempty=0 and rdata=0x5C without any rinc; rinc then -> rempty=1, count=0.
- With count=7, assert rst low asynchronously mid-cycle while winc=1 -> all outputs take reset values immediately; after release, first read attempt sets underflow (FIFO empty).
